// File: rtl/song_mix_sequencer.sv
// song_mix_sequencer: count-in/play sequencer mixing a selected song into keyboard audio with a 7-seg note guide
module song_mix_sequencer #(
   parameter int NUM_SONGS = 3,
   parameter int SAMPLE_W  = 16,
   parameter int BEAT_W    = 8,
   parameter int COUNT_IN  = 3,
   parameter int DIGITS    = 4
) (
   input  logic                          CLOCK_50,
   input  logic                          RST,
   input  logic                          beat_tick,
   input  logic [NUM_SONGS-1:0]          song_sel,
   input  logic                          loop_en,
   input  logic                          mel_en,
   input  logic                          harm_en,
   input  logic                          mix_mode,
   input  logic [NUM_SONGS*BEAT_W-1:0]   song_len,
   input  logic [NUM_SONGS*SAMPLE_W-1:0] song_mel,
   input  logic [NUM_SONGS*SAMPLE_W-1:0] song_harm,
   input  logic [NUM_SONGS*DIGITS*7-1:0] seg_in,
   input  logic [SAMPLE_W-1:0]           key_L,
   input  logic [SAMPLE_W-1:0]           key_R,
   output logic [SAMPLE_W-1:0]           audio_outL,
   output logic [SAMPLE_W-1:0]           audio_outR,
   output logic [DIGITS*7-1:0]           hex,
   output logic [BEAT_W-1:0]             play_beat,
   output logic [1:0]                    state,
   output logic                          song_done
);
   localparam int IDX_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
   typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, PLAY = 2'd2} state_t;
   state_t cur, nxt;
   logic [IDX_W-1:0] active, active_nxt, sel_idx;
   logic [BEAT_W-1:0] beat_nxt, len, last;
   logic done_nxt, sel_ok, abort;
   logic [SAMPLE_W-1:0] mel, harm, mix_l, mix_r;
   logic [DIGITS*7-1:0] hex_nxt;

   function automatic logic [SAMPLE_W-1:0] sat(input logic [SAMPLE_W-1:0] a, input logic [SAMPLE_W-1:0] b);
      logic [SAMPLE_W:0] s;
      s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
      return (s[SAMPLE_W] != s[SAMPLE_W-1]) ? {s[SAMPLE_W], {(SAMPLE_W-1){~s[SAMPLE_W]}}} : s[SAMPLE_W-1:0];
   endfunction

   assign state  = cur;
   assign sel_ok = (song_sel != '0) && ((song_sel & (song_sel - NUM_SONGS'(1))) == '0);
   assign abort  = !sel_ok || (sel_idx != active);
   assign len    = song_len[int'(active)*BEAT_W +: BEAT_W];
   assign last   = (len == '0) ? '0 : len - BEAT_W'(1);
   assign mel    = song_mel[int'(active)*SAMPLE_W +: SAMPLE_W];
   assign harm   = song_harm[int'(active)*SAMPLE_W +: SAMPLE_W];
   assign mix_l  = (cur != PLAY || !mel_en) ? key_L : mix_mode ? sat(key_L, mel) : mel;
   assign mix_r  = (cur != PLAY || !harm_en) ? key_R : mix_mode ? sat(key_R, harm) : harm;

   // decode the one-hot song select into a song index
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_SONGS; i++)
         if (song_sel[i]) sel_idx = IDX_W'(i);
   end

   // next-state: select change aborts before any beat handling
   always_comb begin
      nxt        = cur;
      beat_nxt   = play_beat;
      active_nxt = active;
      done_nxt   = 1'b0;
      case (cur)
         IDLE: begin
            beat_nxt = '0;
            if (sel_ok) begin
               nxt        = COUNT;
               active_nxt = sel_idx;
            end
         end
         COUNT: begin
            if (abort) begin
               nxt      = IDLE;
               beat_nxt = '0;
            end else if (beat_tick) begin
               nxt      = (play_beat == BEAT_W'(COUNT_IN - 1)) ? PLAY : COUNT;
               beat_nxt = (play_beat == BEAT_W'(COUNT_IN - 1)) ? '0 : play_beat + BEAT_W'(1);
            end
         end
         PLAY: begin
            if (abort) begin
               nxt      = IDLE;
               beat_nxt = '0;
            end else if (beat_tick) begin
               done_nxt = (play_beat == last);
               nxt      = (play_beat != last) ? PLAY : loop_en ? COUNT : IDLE;
               beat_nxt = (play_beat == last) ? '0 : play_beat + BEAT_W'(1);
            end
         end
         default: begin
            nxt      = IDLE;
            beat_nxt = '0;
         end
      endcase
   end

   // note guide: COUNT reveals one more digit per beat, PLAY shows all
   always_comb begin
      hex_nxt = '1;
      for (int d = 0; d < DIGITS; d++)
         if (cur == PLAY || (cur == COUNT && BEAT_W'(d) <= play_beat))
            hex_nxt[d*7 +: 7] = seg_in[(int'(active)*DIGITS + d)*7 +: 7];
   end

   // sequencer state register
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         cur       <= IDLE;
         play_beat <= '0;
         active    <= '0;
         song_done <= 1'b0;
      end else begin
         cur       <= nxt;
         play_beat <= beat_nxt;
         active    <= active_nxt;
         song_done <= done_nxt;
      end
   end

   // registered audio and display outputs
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         audio_outL <= '0;
         audio_outR <= '0;
         hex        <= '1;
      end else begin
         audio_outL <= mix_l;
         audio_outR <= mix_r;
         hex        <= hex_nxt;
      end
   end
endmodule

// File: doc/song_mix_sequencer.md
SONG_MIX_SEQUENCER -- requirements
Module: song_mix_sequencer

Interface
REQ-001 SHALL have parameter NUM_SONGS, default 3: number of selectable songs.
REQ-002 SHALL have parameter SAMPLE_W, default 16: signed audio sample width.
REQ-003 SHALL have parameter BEAT_W, default 8: beat counter width.
REQ-004 SHALL have parameter COUNT_IN, default 3: count-in beats before playback, range 1..DIGITS-1.
REQ-005 SHALL have parameter DIGITS, default 4: number of 7-segment note-guide digits.
REQ-006 CLOCK_50  in  1  single system clock; all logic on rising edge.
REQ-007 RST  in  1  reset, synchronous, active-high.
REQ-008 beat_tick  in  1  one-cycle beat pulse.
REQ-009 song_sel  in  NUM_SONGS  song select, valid only when exactly one bit is set.
REQ-010 loop_en  in  1  1 = restart count-in after song end; 0 = return to IDLE.
REQ-011 mel_en, harm_en  in  1 each  route melody to left, harmony to right.
REQ-012 mix_mode  in  1  0 = song replaces keyboard; 1 = saturating sum of song and keyboard.
REQ-013 song_len  in  NUM_SONGS*BEAT_W  per-song length in beats; song i occupies slice i.
REQ-014 song_mel, song_harm  in  NUM_SONGS*SAMPLE_W each  per-song melody/harmony samples.
REQ-015 seg_in  in  NUM_SONGS*DIGITS*7  per-song active-low segment patterns; digit 0 is the lowest slice.
REQ-016 key_L, key_R  in  SAMPLE_W each  live keyboard samples.
REQ-017 audio_outL, audio_outR  out  SAMPLE_W each  registered output samples.
REQ-018 hex  out  DIGITS*7  registered note-guide display, active-low.
REQ-019 play_beat  out  BEAT_W  beat index within the current phase.
REQ-020 state  out  2  0 = IDLE, 1 = COUNT, 2 = PLAY.
REQ-021 song_done  out  1  one-cycle pulse when the last beat completes.

Function
REQ-022 SHALL implement three states: IDLE, COUNT and PLAY.
REQ-023 IDLE: on a cycle with a valid song_sel, SHALL latch the active song index, clear play_beat and enter COUNT on the next cycle.
REQ-024 COUNT: each beat_tick SHALL increment play_beat; on the tick where play_beat==COUNT_IN-1, SHALL clear play_beat and enter PLAY.
REQ-025 PLAY: each beat_tick SHALL increment play_beat; on the tick where play_beat==max(song_len[active],1)-1, SHALL pulse song_done, clear play_beat and enter COUNT if loop_en=1, otherwise IDLE.
REQ-026 In COUNT or PLAY, if song_sel becomes invalid or differs from the latched song, SHALL enter IDLE next cycle with play_beat cleared and no song_done pulse; this rule takes priority over a simultaneous beat_tick.
REQ-027 hex: IDLE SHALL show all digits blank (7'h7F). COUNT SHALL show digits 0..play_beat from seg_in[active] and blank the rest. PLAY SHALL show all digits from seg_in[active].
REQ-028 Outside PLAY: audio_outL=key_L and audio_outR=key_R.
REQ-029 In PLAY, left channel: if mel_en=0, output key_L; if mix_mode=0, output mel; if mix_mode=1, output sat(key_L+mel).
REQ-030 Right channel SHALL follow the same rule using harm_en, key_R and harm.
REQ-031 sat() SHALL compute the sum at SAMPLE_W+1 bits and clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-032 Audio and hex outputs SHALL have 1-cycle latency from their inputs and from the state register.
REQ-033 play_beat SHALL not wrap; song_len is at most 2^BEAT_W-1.

Reset
REQ-034 RST=1 at a clock edge SHALL force: state=IDLE, play_beat=0, song_done=0, hex all 7'h7F, audio outputs 0, active index 0.
REQ-035 RST SHALL take priority over all other inputs, including mid-PLAY; the cycle after RST deasserts behaves as IDLE.

Verification
REQ-036 Select song 1 (song_sel=3'b010), COUNT_IN=3 -> after 3 ticks state=PLAY; hex reveals 1, 2, then 3 digits during COUNT.
REQ-037 Song length 4, loop_en=0 -> song_done pulses on the 4th PLAY tick and state=IDLE next cycle.
REQ-038 mix_mode=1, key_L=16'h7000, mel=16'h2000 -> audio_outL=16'h7FFF; key_L=16'h8000, mel=16'hF000 -> 16'h8000.
REQ-039 Song select changed to 3'b011 mid-PLAY, with a beat_tick on the same cycle -> IDLE, no song_done, audio = keyboard.
REQ-040 RST pulse during PLAY beat 2 -> all outputs at reset values next cycle.
REQ-041 loop_en=1 with song_len=0 -> each PLAY lasts 1 beat, then COUNT restarts, repeated for 3 loops.
